// File: rtl/spi_mem_master.sv
// rtl/spi_mem_master.sv - SPI serial-memory master with READ/WRITE bursts and parked sequential reads
module spi_mem_master #(
    parameter int ADDR_BITS = 24,
    parameter int MAX_BURST = 4,
    parameter int LEN_W     = 3,
    parameter int PAUSE_EN  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LEN_W-1:0]     req_len,
    input  logic [7:0]           wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 cs_n,
    output logic                 hold_n,
    output logic                 sck_en
);

    // The bit counter must cover the longest single phase: the address or a full data burst.
    localparam int CNT_MAX = (8 * MAX_BURST > ADDR_BITS) ? 8 * MAX_BURST : ADDR_BITS;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [2:0] {IDLE, GAP, CMD, ADDR, RDATA, WDATA, WSTALL, PAUSE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [ADDR_BITS+7:0] sh;
    logic [7:0]           wsh;
    logic [6:0]           rsh;
    logic [LEN_W-1:0]     len_q, blen, len_eff;
    logic [ADDR_BITS-1:0] next_addr;
    logic                 is_write, armed, accept, resume, boundary, cnt_zero;

    assign len_eff  = (req_len == '0) ? LEN_W'(1) : req_len;
    assign accept   = req_valid & req_ready;
    assign resume   = (state == PAUSE) & ~req_write & (req_addr == next_addr);
    assign cnt_zero = (cnt == '0);
    // A write byte is needed on the last address bit, on the last bit of a non-final byte, or while stalled.
    assign boundary = ((state == ADDR) & is_write & cnt_zero)
                    | ((state == WDATA) & cnt_zero & (blen != '0))
                    | (state == WSTALL);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = GAP;
            PAUSE:   if (accept) state_nxt = resume ? RDATA : GAP;
            GAP:     state_nxt = CMD;
            CMD:     if (cnt_zero) state_nxt = ADDR;
            ADDR:    if (cnt_zero) state_nxt = !is_write ? RDATA : (wr_valid ? WDATA : WSTALL);
            RDATA:   if (cnt_zero) state_nxt = (PAUSE_EN != 0) ? PAUSE : IDLE;
            WDATA:   if (cnt_zero) state_nxt = (blen == '0) ? IDLE : (wr_valid ? WDATA : WSTALL);
            WSTALL:  if (wr_valid) state_nxt = WDATA;
            default: state_nxt = IDLE;
        endcase
    end

    // Pin and handshake outputs decoded from the current state
    always_comb begin
        cs_n      = 1'b1;
        hold_n    = 1'b1;
        sck_en    = 1'b0;
        mosi      = 1'b0;
        req_ready = 1'b0;
        wr_ready  = wr_valid & boundary;
        case (state)
            IDLE:       req_ready = armed;
            PAUSE:      begin cs_n = 1'b0; hold_n = 1'b0; req_ready = armed; end
            CMD, ADDR:  begin cs_n = 1'b0; sck_en = 1'b1; mosi = sh[ADDR_BITS+7]; end
            RDATA:      begin cs_n = 1'b0; sck_en = 1'b1; end
            WDATA:      begin cs_n = 1'b0; sck_en = 1'b1; mosi = wsh[7]; end
            WSTALL:     begin cs_n = 1'b0; hold_n = 1'b0; end
            default:    ;
        endcase
    end

    // Shift registers, bit/byte counters, read capture and sequential-address tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            sh        <= '0;
            wsh       <= '0;
            rsh       <= '0;
            len_q     <= '0;
            blen      <= '0;
            next_addr <= '0;
            is_write  <= 1'b0;
            armed     <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            armed    <= 1'b1;
            rd_valid <= 1'b0;
            case (state)
                IDLE, PAUSE: if (accept) begin
                    is_write <= req_write;
                    len_q    <= len_eff;
                    blen     <= len_eff;
                    sh       <= {(req_write ? 8'h02 : 8'h03), req_addr};
                    if (!req_write) next_addr <= req_addr + ADDR_BITS'(len_eff);
                    cnt      <= resume ? CW'({len_eff - LEN_W'(1), 3'b111}) : CW'(7);
                end
                CMD: begin
                    sh  <= sh << 1;
                    cnt <= cnt_zero ? CW'(ADDR_BITS - 1) : cnt - CW'(1);
                end
                ADDR: begin
                    sh <= sh << 1;
                    if (cnt_zero) cnt <= is_write ? CW'(7) : CW'({len_q - LEN_W'(1), 3'b111});
                    else          cnt <= cnt - CW'(1);
                end
                RDATA: begin
                    rsh <= {rsh[5:0], miso};
                    if (cnt[2:0] == 3'd0) begin
                        rd_data  <= {rsh, miso};
                        rd_valid <= 1'b1;
                    end
                    cnt <= cnt - CW'(1);
                end
                WDATA: begin
                    wsh <= wsh << 1;
                    cnt <= cnt_zero ? CW'(7) : cnt - CW'(1);
                end
                default: ;
            endcase
            // Latching a new byte takes priority over the shift of the byte just finished.
            if (wr_ready) begin
                wsh  <= wr_data;
                blen <= blen - LEN_W'(1);
            end
        end
    end

endmodule
